int_sequencer: RTL and testbench

- Controls the interrupt vectoring unit (pending latch + priority encoder + vector mux).
- Sequences the full interrupt entry/exit handshake with the CPU: arbitrate at an instruction boundary, save the return PC, load the vector, clear the latched requests, run the ISR, restore the PC on RTI.
- Owns the global interrupt enable and drives the vectoring unit's `en` input.
- Sits between the vectoring unit and the PC/fetch logic.

---
 rtl/int_pkg.sv | 20 ++
 rtl/isr_watchdog.sv | 58 +++++
 rtl/int_sequencer.sv | 96 +++++++++
 tb/tb_int_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared constants for the interrupt sequencer: state encoding, default
// widths and the fixed ISR entry addresses of the vectoring unit.
package int_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM    = 3'd1;
  localparam logic [2:0] VECTOR = 3'd2;
  localparam logic [2:0] ISR    = 3'd3;
  localparam logic [2:0] RETURN = 3'd4;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_TO_W    = 8;
  localparam int DEF_TIMEOUT = 255;

  localparam logic [7:0] VEC_ZERO     = 8'h00;
  localparam logic [7:0] VEC_OVERFLOW = 8'h01;
  localparam logic [7:0] VEC_ILLEGAL  = 8'h02;
  localparam logic [7:0] VEC_EXTERNAL = 8'h04;

endpackage

// File: rtl/isr_watchdog.sv
// ISR watchdog: cycle counter restarted on ISR entry, saturating at TIMEOUT,
// with a sticky expiry flag that only to_clr or clr can drop.
module isr_watchdog
  import int_pkg::*;
#(
  parameter int TO_W    = DEF_TO_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic run,
  input  logic to_clr,
  output logic expire,
  output logic flag
);

  localparam logic [TO_W-1:0] CNT_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            flag_q, flag_d;

  // run is already qualified by the caller with "no rti this cycle", so an
  // rti in the last allowed cycle never raises the flag.
  assign expire = run && (cnt_q == CNT_LAST);
  assign flag   = flag_q;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (start) begin
      cnt_d = '0;
    end else if (run && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (expire) begin
      flag_d = 1'b1;
    end else if (to_clr) begin
      flag_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: arbitrates at instruction boundaries,
// saves the return PC, vectors to the ISR and restores the PC on RTI.
module int_sequencer
  import int_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TO_W    = DEF_TO_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              irq_pending,
  input  logic [ADDR_W-1:0] vec_addr,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              instr_boundary,
  input  logic              rti,
  input  logic              gie_set,
  input  logic              gie_clr,
  input  logic              to_clr,
  output logic              int_en,
  output logic              i_clr,
  output logic              stall,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] epc,
  output logic              in_isr,
  output logic              isr_timeout
);

  logic [2:0]        state_q, state_d;
  logic              gie_q, gie_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic              wd_expire;

  isr_watchdog #(
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .clr   (clr),
    .start (state_q == VECTOR),
    .run   ((state_q == ISR) && !rti),
    .to_clr(to_clr),
    .expire(wd_expire),
    .flag  (isr_timeout)
  );

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    vec_d   = vec_q;
    gie_d   = gie_clr ? 1'b0 : (gie_set ? 1'b1 : gie_q);
    case (state_q)
      IDLE: if (irq_pending && gie_q) state_d = ARM;
      ARM: begin
        // Dropping the enable or the request aborts before anything is captured.
        if (gie_clr || !irq_pending) begin
          state_d = IDLE;
        end else if (instr_boundary) begin
          epc_d   = pc_cur;
          vec_d   = vec_addr;
          state_d = VECTOR;
        end
      end
      VECTOR: state_d = ISR;
      ISR:    if (rti || wd_expire) state_d = RETURN;
      RETURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      gie_q   <= 1'b0;
      epc_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      gie_q   <= gie_d;
      epc_q   <= epc_d;
      vec_q   <= vec_d;
    end
  end

  assign int_en  = gie_q && (state_q == IDLE || state_q == ARM);
  assign i_clr   = (state_q == VECTOR);
  assign stall   = (state_q == VECTOR) || (state_q == RETURN);
  assign pc_load = stall;
  assign pc_next = (state_q == VECTOR) ? vec_q :
                   (state_q == RETURN) ? epc_q : '0;
  assign epc     = epc_q;
  assign in_isr  = (state_q == ISR);

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed handshake scenarios followed by random
// stimulus, all checked each cycle against a behavioural model.
module tb_int_sequencer;
  import int_pkg::*;

  localparam int AW   = 8;
  localparam int TOUT = 8;

  logic          clk = 1'b0;
  logic          clr, irq_pending, instr_boundary, rti, gie_set, gie_clr, to_clr;
  logic [AW-1:0] vec_addr, pc_cur;
  logic          int_en, i_clr, stall, pc_load, in_isr, isr_timeout;
  logic [AW-1:0] pc_next, epc;

  always #5 clk = ~clk;

  int_sequencer #(.ADDR_W(AW), .TO_W(8), .TIMEOUT(TOUT)) dut (
    .clk(clk), .clr(clr), .irq_pending(irq_pending), .vec_addr(vec_addr),
    .pc_cur(pc_cur), .instr_boundary(instr_boundary), .rti(rti),
    .gie_set(gie_set), .gie_clr(gie_clr), .to_clr(to_clr),
    .int_en(int_en), .i_clr(i_clr), .stall(stall), .pc_load(pc_load),
    .pc_next(pc_next), .epc(epc), .in_isr(in_isr), .isr_timeout(isr_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: where we are in the handshake, described by what has happened.
  bit          m_gie, m_armed, m_vec, m_ret, m_to;
  int          m_age;              // ISR cycles elapsed including current, 0 = not in ISR
  logic [AW-1:0] m_epc, m_target;

  function automatic logic [21:0] model_outs();
    bit busy;
    logic [AW-1:0] nxt;
    busy = m_vec || m_ret || (m_age > 0);
    nxt  = m_vec ? m_target : (m_ret ? m_epc : '0);
    return {m_gie && !busy, m_vec, m_vec || m_ret, m_vec || m_ret,
            m_age > 0, m_to, nxt, m_epc};
  endfunction

  logic [21:0] dut_outs;
  assign dut_outs = {int_en, i_clr, stall, pc_load, in_isr, isr_timeout, pc_next, epc};

  task automatic step();
    bit n_gie, n_armed, n_vec, n_ret, n_to, set_to;
    int n_age;
    logic [AW-1:0] n_epc, n_target;
    n_gie = m_gie; n_armed = m_armed; n_vec = m_vec; n_ret = m_ret; n_to = m_to;
    n_age = m_age; n_epc = m_epc; n_target = m_target; set_to = 1'b0;
    if (clr) begin
      n_gie = 0; n_armed = 0; n_vec = 0; n_ret = 0; n_to = 0; n_age = 0;
      n_epc = '0; n_target = '0;
    end else begin
      n_gie = gie_clr ? 1'b0 : (gie_set ? 1'b1 : m_gie);
      if (m_vec) begin
        n_vec = 0; n_age = 1;
      end else if (m_ret) begin
        n_ret = 0;
      end else if (m_age > 0) begin
        if (rti) begin
          n_age = 0; n_ret = 1;
        end else if (m_age == TOUT) begin
          n_age = 0; n_ret = 1; set_to = 1'b1;
        end else begin
          n_age = m_age + 1;
        end
      end else if (m_armed) begin
        if (gie_clr || !irq_pending) begin
          n_armed = 0;
        end else if (instr_boundary) begin
          n_armed = 0; n_vec = 1; n_epc = pc_cur; n_target = vec_addr;
        end
      end else begin
        n_armed = irq_pending && m_gie;
      end
      if (set_to) n_to = 1'b1;
      else if (to_clr) n_to = 1'b0;
    end
    @(posedge clk);
    #1;
    m_gie = n_gie; m_armed = n_armed; m_vec = n_vec; m_ret = n_ret; m_to = n_to;
    m_age = n_age; m_epc = n_epc; m_target = n_target;
    check("cycle_outputs", 32'(dut_outs), 32'(model_outs()));
  endtask

  // Drive a request from IDLE (gie already set) through to the first ISR cycle.
  task automatic enter_isr(input logic [AW-1:0] v, input logic [AW-1:0] pc);
    irq_pending = 1'b1; vec_addr = v; pc_cur = pc;
    step();
    instr_boundary = 1'b1;
    step();
    instr_boundary = 1'b0; irq_pending = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] vecs [4];
    vecs[0] = VEC_ZERO; vecs[1] = VEC_OVERFLOW; vecs[2] = VEC_ILLEGAL; vecs[3] = VEC_EXTERNAL;
    clr = 1'b1; irq_pending = 0; instr_boundary = 0; rti = 0;
    gie_set = 0; gie_clr = 0; to_clr = 0; vec_addr = '0; pc_cur = '0;
    m_gie = 0; m_armed = 0; m_vec = 0; m_ret = 0; m_to = 0; m_age = 0;
    m_epc = '0; m_target = '0;
    step();
    step();
    check("reset_outputs", 32'(dut_outs), 32'd0);
    clr = 1'b0;

    // Normal entry and RTI exit.
    gie_set = 1'b1;
    step();
    gie_set = 1'b0; irq_pending = 1'b1; vec_addr = VEC_EXTERNAL; pc_cur = 8'h3A;
    step();
    step();
    instr_boundary = 1'b1;
    step();
    check("vector_pc_load", 32'(pc_load), 32'd1);
    check("vector_pc_next", 32'(pc_next), 32'h04);
    check("vector_i_clr", 32'(i_clr), 32'd1);
    instr_boundary = 1'b0; irq_pending = 1'b0;
    step();
    check("isr_i_clr_once", 32'(i_clr), 32'd0);
    check("isr_in_isr", 32'(in_isr), 32'd1);
    check("isr_epc", 32'(epc), 32'h3A);
    repeat (4) step();
    rti = 1'b1;
    step();
    check("return_pc_next", 32'(pc_next), 32'h3A);
    check("return_pc_load", 32'(pc_load), 32'd1);
    rti = 1'b0;
    step();
    check("idle_int_en", 32'(int_en), 32'd1);
    check("idle_pc_load", 32'(pc_load), 32'd0);

    // Request held while disabled, then enable, then abort in ARM.
    gie_clr = 1'b1;
    step();
    gie_clr = 1'b0; irq_pending = 1'b1;
    repeat (20) step();
    check("disabled_int_en", 32'(int_en), 32'd0);
    check("disabled_pc_load", 32'(pc_load), 32'd0);
    gie_set = 1'b1;
    step();
    gie_set = 1'b0;
    step();
    check("armed_int_en", 32'(int_en), 32'd1);
    pc_cur = 8'h77; gie_clr = 1'b1; instr_boundary = 1'b1;
    step();
    check("abort_i_clr", 32'(i_clr), 32'd0);
    check("abort_pc_load", 32'(pc_load), 32'd0);
    check("abort_epc_kept", 32'(epc), 32'h3A);
    gie_clr = 1'b0; instr_boundary = 1'b0;
    step();
    check("abort_int_en", 32'(int_en), 32'd0);

    // Watchdog expiry, with to_clr colliding with the set event.
    gie_set = 1'b1; irq_pending = 1'b0;
    step();
    gie_set = 1'b0;
    enter_isr(VEC_OVERFLOW, 8'h55);
    repeat (6) step();
    to_clr = 1'b1;
    step();
    check("timeout_last_isr", 32'(in_isr), 32'd1);
    step();
    check("timeout_return_pc", 32'(pc_next), 32'h55);
    check("timeout_flag_set", 32'(isr_timeout), 32'd1);
    to_clr = 1'b0;
    repeat (4) step();
    check("timeout_flag_sticky", 32'(isr_timeout), 32'd1);
    to_clr = 1'b1;
    step();
    check("timeout_flag_cleared", 32'(isr_timeout), 32'd0);
    to_clr = 1'b0;

    // RTI in the final allowed ISR cycle is a normal return.
    enter_isr(VEC_ILLEGAL, 8'h20);
    repeat (7) step();
    rti = 1'b1;
    step();
    check("rti_at_limit_pc", 32'(pc_next), 32'h20);
    check("rti_at_limit_flag", 32'(isr_timeout), 32'd0);
    rti = 1'b0;
    step();

    // Reset mid-ISR.
    enter_isr(VEC_ZERO, 8'h99);
    step();
    clr = 1'b1;
    step();
    check("clr_mid_isr", 32'(dut_outs), 32'd0);
    clr = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      clr            = ($urandom_range(0, 199) == 0);
      irq_pending    = ($urandom_range(0, 3) != 0);
      instr_boundary = ($urandom_range(0, 1) == 1);
      rti            = ($urandom_range(0, 5) == 0);
      gie_set        = ($urandom_range(0, 7) == 0);
      gie_clr        = ($urandom_range(0, 15) == 0);
      to_clr         = ($urandom_range(0, 15) == 0);
      vec_addr       = ($urandom_range(0, 1) == 1) ? vecs[$urandom_range(0, 3)] : 8'($urandom);
      pc_cur         = 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
